// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - single-issue ALU sequencer: MIPS decode, operand latch, overflow check, writeback handshake
module alu_issue #(
  parameter int W_CPU    = 32,
  parameter int W_OPCODE = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [31:0]         instr,
  input  logic [W_CPU-1:0]    rs_val,
  input  logic [W_CPU-1:0]    rt_val,
  output logic [W_OPCODE-1:0] alu_op,
  output logic [W_CPU-1:0]    alu_a,
  output logic [W_CPU-1:0]    alu_b,
  input  logic [W_CPU-1:0]    alu_r,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [W_CPU-1:0]    rsp_data,
  output logic [4:0]          rsp_dest,
  output logic                rsp_we,
  output logic                rsp_zero,
  output logic                rsp_ovf,
  output logic                rsp_illegal
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  typedef enum logic [1:0] {OVF_NONE, OVF_ADD, OVF_SUB} ovf_t;

  state_t state;
  ovf_t   ovf_kind;
  logic [4:0] dest_q;

  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic [W_CPU-1:0] imm_sx;
  logic [W_CPU-1:0] imm_zx;
  logic [W_CPU-1:0] shamt_zx;
  logic [W_CPU-1:0] rs_sh_zx;
  logic             unused_rs_field;

  assign opcode          = instr[31:26];
  assign funct           = instr[5:0];
  assign imm_sx          = {{(W_CPU-16){instr[15]}}, instr[15:0]};
  assign imm_zx          = W_CPU'(instr[15:0]);
  assign shamt_zx        = W_CPU'(instr[10:6]);
  assign rs_sh_zx        = W_CPU'(rs_val[4:0]);
  assign unused_rs_field = ^instr[25:21];

  logic             dec_legal;
  logic [5:0]       dec_op;
  logic [W_CPU-1:0] dec_a;
  logic [W_CPU-1:0] dec_b;
  logic [4:0]       dec_dest;
  ovf_t             dec_ovf;

  always_comb begin
    dec_legal = 1'b1;
    dec_op    = funct;
    dec_a     = rs_val;
    dec_b     = rt_val;
    dec_dest  = instr[15:11];
    dec_ovf   = OVF_NONE;
    if (opcode == 6'h00) begin
      case (funct)
        6'h00, 6'h02, 6'h03: begin
          dec_a = rt_val;
          dec_b = shamt_zx;
        end
        6'h04, 6'h06, 6'h07: begin
          dec_a = rt_val;
          dec_b = rs_sh_zx;
        end
        6'h20: dec_ovf = OVF_ADD;
        6'h22: dec_ovf = OVF_SUB;
        6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B: begin
        end
        default: dec_legal = 1'b0;
      endcase
    end else begin
      dec_dest = instr[20:16];
      dec_op   = opcode;
      case (opcode)
        6'h08: begin
          dec_b   = imm_sx;
          dec_ovf = OVF_ADD;
        end
        6'h09, 6'h0A: dec_b = imm_sx;
        6'h0E:        dec_b = imm_zx;
        // ANDI/ORI reuse the R-type AND/OR encodings so the ALU needs no immediate variants
        6'h0C: begin
          dec_op = 6'h24;
          dec_b  = imm_zx;
        end
        6'h0D: begin
          dec_op = 6'h25;
          dec_b  = imm_zx;
        end
        default: dec_legal = 1'b0;
      endcase
    end
  end

  logic a_msb;
  logic b_msb;
  logic r_msb;
  logic ovf_now;

  assign a_msb   = alu_a[W_CPU-1];
  assign b_msb   = alu_b[W_CPU-1];
  assign r_msb   = alu_r[W_CPU-1];
  assign ovf_now = ((ovf_kind == OVF_ADD) && (a_msb == b_msb) && (r_msb != a_msb)) ||
                   ((ovf_kind == OVF_SUB) && (a_msb != b_msb) && (r_msb != a_msb));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      req_ready   <= 1'b1;
      ovf_kind    <= OVF_NONE;
      dest_q      <= '0;
      alu_op      <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_dest    <= '0;
      rsp_we      <= 1'b0;
      rsp_zero    <= 1'b0;
      rsp_ovf     <= 1'b0;
      rsp_illegal <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            if (dec_legal) begin
              alu_op   <= W_OPCODE'(dec_op);
              alu_a    <= dec_a;
              alu_b    <= dec_b;
              dest_q   <= dec_dest;
              ovf_kind <= dec_ovf;
              state    <= EXEC;
            end else begin
              // illegal ops skip EXEC and leave the ALU operands untouched
              rsp_data    <= '0;
              rsp_dest    <= '0;
              rsp_we      <= 1'b0;
              rsp_zero    <= 1'b1;
              rsp_ovf     <= 1'b0;
              rsp_illegal <= 1'b1;
              rsp_valid   <= 1'b1;
              state       <= RESP;
            end
          end
        end
        EXEC: begin
          rsp_data    <= alu_r;
          rsp_dest    <= dest_q;
          rsp_zero    <= (alu_r == '0);
          rsp_ovf     <= ovf_now;
          rsp_we      <= !ovf_now && (dest_q != 5'd0);
          rsp_illegal <= 1'b0;
          rsp_valid   <= 1'b1;
          state       <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - randomized scoreboard bench for alu_issue
module tb_alu_issue;

  typedef struct {
    logic        illegal;
    logic [31:0] data;
    logic [4:0]  dest;
    logic        we;
    logic        ovf;
    logic        zero;
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          acc;
  } exp_t;

  localparam logic [5:0] R_FNS [16] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21,
                                        6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
  localparam logic [5:0] I_OPS [6]  = '{6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] instr = '0;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic [5:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_r;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_dest;
  logic        rsp_we;
  logic        rsp_zero;
  logic        rsp_ovf;
  logic        rsp_illegal;

  alu_issue #(.W_CPU(32), .W_OPCODE(6)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .instr(instr),
    .rs_val(rs_val), .rt_val(rt_val), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_r(alu_r), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_dest(rsp_dest), .rsp_we(rsp_we), .rsp_zero(rsp_zero), .rsp_ovf(rsp_ovf),
    .rsp_illegal(rsp_illegal)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // external combinational ALU the block drives
  always_comb begin
    case (alu_op)
      6'h00, 6'h04:               alu_r = alu_a << alu_b[4:0];
      6'h02, 6'h06:               alu_r = alu_a >> alu_b[4:0];
      6'h03, 6'h07:               alu_r = $signed(alu_a) >>> alu_b[4:0];
      6'h20, 6'h21, 6'h08, 6'h09: alu_r = alu_a + alu_b;
      6'h22, 6'h23:               alu_r = alu_a - alu_b;
      6'h24:                      alu_r = alu_a & alu_b;
      6'h25:                      alu_r = alu_a | alu_b;
      6'h26, 6'h0E:               alu_r = alu_a ^ alu_b;
      6'h27:                      alu_r = ~(alu_a | alu_b);
      6'h2A, 6'h0A:               alu_r = {31'd0, $signed(alu_a) < $signed(alu_b)};
      6'h2B:                      alu_r = {31'd0, alu_a < alu_b};
      default:                    alu_r = '0;
    endcase
  end

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  logic [5:0]  m_op = '0;
  logic [31:0] m_a = '0;
  logic [31:0] m_b = '0;
  int   last_accept = 0;
  int   last_hs = 0;
  logic rand_ready = 1'b0;
  logic ready_cmd = 1'b1;

  task automatic check(input bit ok, input string name, input string detail);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                        input logic [4:0] sh, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // instruction semantics from the MIPS definitions, overflow from wide signed arithmetic
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
    exp_t        e;
    logic [5:0]  opc;
    logic [5:0]  fn;
    logic [4:0]  sh;
    logic [31:0] sx;
    logic [31:0] zx;
    longint      lim;
    longint      s;
    opc = ins[31:26];
    fn  = ins[5:0];
    sh  = ins[10:6];
    sx  = {{16{ins[15]}}, ins[15:0]};
    zx  = {16'd0, ins[15:0]};
    lim = 64'sh7FFF_FFFF;
    e.illegal = 1'b0;
    e.ovf  = 1'b0;
    e.a    = rs;
    e.b    = rt;
    e.data = '0;
    e.acc  = 0;
    if (opc == 6'h00) begin
      e.dest = ins[15:11];
      e.op   = fn;
      case (fn)
        6'h00: begin e.a = rt; e.b = {27'd0, sh}; e.data = rt << sh; end
        6'h02: begin e.a = rt; e.b = {27'd0, sh}; e.data = rt >> sh; end
        6'h03: begin e.a = rt; e.b = {27'd0, sh}; e.data = $signed(rt) >>> sh; end
        6'h04: begin e.a = rt; e.b = {27'd0, rs[4:0]}; e.data = rt << rs[4:0]; end
        6'h06: begin e.a = rt; e.b = {27'd0, rs[4:0]}; e.data = rt >> rs[4:0]; end
        6'h07: begin e.a = rt; e.b = {27'd0, rs[4:0]}; e.data = $signed(rt) >>> rs[4:0]; end
        6'h20: begin
          s = longint'($signed(rs)) + longint'($signed(rt));
          e.data = rs + rt;
          e.ovf  = (s > lim) || (s < -lim - 1);
        end
        6'h21: e.data = rs + rt;
        6'h22: begin
          s = longint'($signed(rs)) - longint'($signed(rt));
          e.data = rs - rt;
          e.ovf  = (s > lim) || (s < -lim - 1);
        end
        6'h23: e.data = rs - rt;
        6'h24: e.data = rs & rt;
        6'h25: e.data = rs | rt;
        6'h26: e.data = rs ^ rt;
        6'h27: e.data = ~(rs | rt);
        6'h2A: e.data = ($signed(rs) < $signed(rt)) ? 32'd1 : 32'd0;
        6'h2B: e.data = (rs < rt) ? 32'd1 : 32'd0;
        default: e.illegal = 1'b1;
      endcase
    end else begin
      e.dest = ins[20:16];
      e.op   = opc;
      case (opc)
        6'h08: begin
          s = longint'($signed(rs)) + longint'($signed(sx));
          e.b = sx; e.data = rs + sx;
          e.ovf = (s > lim) || (s < -lim - 1);
        end
        6'h09: begin e.b = sx; e.data = rs + sx; end
        6'h0A: begin e.b = sx; e.data = ($signed(rs) < $signed(sx)) ? 32'd1 : 32'd0; end
        6'h0C: begin e.op = 6'h24; e.b = zx; e.data = rs & zx; end
        6'h0D: begin e.op = 6'h25; e.b = zx; e.data = rs | zx; end
        6'h0E: begin e.b = zx; e.data = rs ^ zx; end
        default: e.illegal = 1'b1;
      endcase
    end
    if (e.illegal) begin
      e.data = '0; e.dest = '0; e.ovf = 1'b0; e.we = 1'b0; e.zero = 1'b1;
      e.op = m_op; e.a = m_a; e.b = m_b;
    end else begin
      e.we = !e.ovf && (e.dest != 5'd0);
      e.zero = (e.data == 32'd0);
      m_op = e.op; m_a = e.a; m_b = e.b;
    end
    return e;
  endfunction

  // returns at the falling edge after the accepting edge, with req_valid dropped
  task automatic issue(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
    exp_t e;
    int   guard;
    @(negedge clk);
    req_valid = 1'b1; instr = ins; rs_val = rs; rt_val = rt;
    guard = 0;
    while (!req_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      check(1'b0, "accept_timeout", $sformatf("req_ready=%b after %0d cycles, required 1", req_ready, guard));
      req_valid = 1'b0;
      return;
    end
    e = model(ins, rs, rt);
    e.acc = cyc;
    last_accept = cyc;
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    check(alu_op == e.op && alu_a == e.a && alu_b == e.b, "alu_regs",
          $sformatf("instr=%h got op=%h a=%h b=%h, required op=%h a=%h b=%h",
                    ins, alu_op, alu_a, alu_b, e.op, e.a, e.b));
  endtask

  task automatic wait_rsp();
    int g = 0;
    while (!rsp_valid && g < 20) begin
      @(negedge clk);
      g++;
    end
    check(rsp_valid, "rsp_timeout", $sformatf("rsp_valid=%b, required 1", rsp_valid));
  endtask

  task automatic drain();
    int g = 0;
    while ((sb.size() != 0 || rsp_valid) && g < 500) begin
      @(negedge clk);
      g++;
    end
    check(sb.size() == 0 && !rsp_valid, "drain",
          $sformatf("pending=%0d rsp_valid=%b, required 0 and 0", sb.size(), rsp_valid));
  endtask

  always @(posedge clk) begin
    #1;
    rsp_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_cmd;
  end

  // monitor: pops on each new response, then checks the held outputs stay put until taken
  exp_t        cur;
  bit          pend = 1'b0;
  logic [41:0] snap;
  always @(negedge clk) begin
    if (rst) begin
      pend = 1'b0;
    end else if (rsp_valid) begin
      if (!pend) begin
        if (sb.size() == 0) begin
          check(1'b0, "unexpected_rsp", $sformatf("rsp_valid=1 data=%h with no request outstanding", rsp_data));
        end else begin
          cur = sb.pop_front();
          check(rsp_data == cur.data && rsp_dest == cur.dest && rsp_we == cur.we && rsp_ovf == cur.ovf &&
                rsp_illegal == cur.illegal && (cur.illegal || rsp_zero == cur.zero), "rsp_fields",
                $sformatf("got data=%h dest=%0d we=%b ovf=%b ill=%b zero=%b, required data=%h dest=%0d we=%b ovf=%b ill=%b zero=%b",
                          rsp_data, rsp_dest, rsp_we, rsp_ovf, rsp_illegal, rsp_zero,
                          cur.data, cur.dest, cur.we, cur.ovf, cur.illegal, cur.zero));
          check(cyc - cur.acc == (cur.illegal ? 1 : 2), "latency",
                $sformatf("got %0d cycles, required %0d", cyc - cur.acc, cur.illegal ? 1 : 2));
        end
        snap = {rsp_data, rsp_dest, rsp_we, rsp_zero, rsp_ovf, rsp_illegal};
      end else begin
        check(snap == {rsp_data, rsp_dest, rsp_we, rsp_zero, rsp_ovf, rsp_illegal}, "rsp_stable",
              $sformatf("got %h, required %h", {rsp_data, rsp_dest, rsp_we, rsp_zero, rsp_ovf, rsp_illegal}, snap));
      end
      pend = !rsp_ready;
      if (rsp_ready) last_hs = cyc;
    end else begin
      pend = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      4: return 32'h0000_0001;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    logic [31:0] ins;
    int k;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check(req_ready && !rsp_valid && rsp_data == 0 && rsp_dest == 0 && !rsp_we && !rsp_zero && !rsp_ovf &&
          !rsp_illegal && alu_op == 0 && alu_a == 0 && alu_b == 0, "reset_state",
          $sformatf("req_ready=%b rsp_valid=%b data=%h op=%h a=%h b=%h, required 1,0,0,0,0,0",
                    req_ready, rsp_valid, rsp_data, alu_op, alu_a, alu_b));
    rst = 1'b0;

    issue(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h21), 32'd5, 32'd7);
    wait_rsp();
    check(rsp_data == 32'd12 && rsp_dest == 5'd3 && rsp_we && !rsp_zero, "addu_directed",
          $sformatf("got data=%h dest=%0d we=%b zero=%b, required 0000000c 3 1 0", rsp_data, rsp_dest, rsp_we, rsp_zero));
    drain();

    issue(itype(6'h08, 5'd1, 5'd4, 16'h0001), 32'h7FFF_FFFF, 32'd0);
    wait_rsp();
    check(rsp_data == 32'h8000_0000 && rsp_ovf && !rsp_we, "addi_ovf",
          $sformatf("got data=%h ovf=%b we=%b, required 80000000 1 0", rsp_data, rsp_ovf, rsp_we));
    drain();
    issue(itype(6'h09, 5'd1, 5'd4, 16'h0001), 32'h7FFF_FFFF, 32'd0);
    wait_rsp();
    check(rsp_data == 32'h8000_0000 && !rsp_ovf && rsp_we, "addiu_no_ovf",
          $sformatf("got data=%h ovf=%b we=%b, required 80000000 0 1", rsp_data, rsp_ovf, rsp_we));
    drain();

    issue(itype(6'h0D, 5'd1, 5'd5, 16'h8000), 32'h1234_0000, 32'd0);
    check(alu_op == 6'h25 && alu_b == 32'h0000_8000, "ori_remap",
          $sformatf("got op=%h b=%h, required 25 00008000", alu_op, alu_b));
    drain();
    issue(rtype(5'd0, 5'd2, 5'd9, 5'd4, 6'h03), 32'd0, 32'hF000_0000);
    check(alu_a == 32'hF000_0000 && alu_b == 32'd4, "sra_operands",
          $sformatf("got a=%h b=%h, required f0000000 00000004", alu_a, alu_b));
    wait_rsp();
    check(rsp_data == 32'hFF00_0000, "sra_result", $sformatf("got %h, required ff000000", rsp_data));
    drain();

    ready_cmd = 1'b0;
    @(posedge clk);
    #2;
    issue(rtype(5'd1, 5'd2, 5'd6, 5'd0, 6'h23), 32'd100, 32'd1);
    fork
      issue(rtype(5'd1, 5'd2, 5'd7, 5'd0, 6'h26), 32'hA5A5_0000, 32'h0000_5A5A);
    join_none
    repeat (5) begin
      @(negedge clk);
      check(!req_ready && rsp_valid, "backpressure_hold",
            $sformatf("got req_ready=%b rsp_valid=%b, required 0 1", req_ready, rsp_valid));
    end
    ready_cmd = 1'b1;
    wait fork;
    check(last_accept == last_hs + 1, "accept_after_release",
          $sformatf("accepted at cycle %0d, required %0d", last_accept, last_hs + 1));
    drain();

    issue(32'hFC00_0000, 32'd3, 32'd4);
    check(rsp_valid && rsp_illegal && !rsp_we, "illegal_3f",
          $sformatf("got valid=%b illegal=%b we=%b, required 1 1 0", rsp_valid, rsp_illegal, rsp_we));
    drain();

    issue(rtype(5'd1, 5'd2, 5'd8, 5'd0, 6'h20), 32'd11, 32'd22);
    rst = 1'b1;
    @(negedge clk);
    check(req_ready && !rsp_valid && rsp_data == 0 && rsp_dest == 0 && !rsp_we && !rsp_zero && !rsp_ovf &&
          !rsp_illegal && alu_op == 0 && alu_a == 0 && alu_b == 0, "reset_in_exec",
          $sformatf("req_ready=%b rsp_valid=%b data=%h op=%h a=%h b=%h, required 1,0,0,0,0,0",
                    req_ready, rsp_valid, rsp_data, alu_op, alu_a, alu_b));
    sb.delete();
    m_op = '0; m_a = '0; m_b = '0;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check(!rsp_valid, "no_rsp_after_reset", $sformatf("rsp_valid=%b, required 0", rsp_valid));
    end
    issue(rtype(5'd1, 5'd2, 5'd10, 5'd0, 6'h22), 32'd50, 32'd8);
    drain();

    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      k = $urandom_range(0, 9);
      if (k <= 4)
        ins = rtype(5'($urandom()), 5'($urandom()), 5'($urandom()), 5'($urandom()), R_FNS[$urandom_range(0, 15)]);
      else if (k <= 7)
        ins = itype(I_OPS[$urandom_range(0, 5)], 5'($urandom()), 5'($urandom()), 16'($urandom()));
      else if (k == 8)
        ins = $urandom() & 32'h03FF_FFFF;
      else
        ins = $urandom();
      issue(ins, pick_val(), pick_val());
    end
    rand_ready = 1'b0;
    ready_cmd = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
